booth_divider: RTL and testbench
================================

// Module: booth_divider
// PURPOSE
//  Iterative radix-2 restoring divider: the inverse datapath to the Booth multiplier.
//  Shares the multiplier's operand format (33-bit signed; bit 32 = sign extension, or 0 for unsigned ops).
//  Shares the multiplier's valid/ready handshakes on both sides.
//  Sits beside the multiplier in the execute stage and returns {remainder, quotient} for one division at a time.
// PARAMETERS
//  XLEN   32   architectural width; operands are XLEN+1 bits, res is 2*XLEN bits
// PORTS
//  clk      in   1         clock; all state updates on rising edge
//  rst_n    in   1         synchronous active-low reset
//  data1    in   XLEN+1    dividend, two's complement
//  data2    in   XLEN+1    divisor, two's complement
//  valid_i  in   1         upstream operands valid
//  ready_o  out  1         divider can accept operands
//  ready_i  in   1         downstream can take result
//  valid_o  out  1         res valid
//  res      out  2*XLEN    {remainder[XLEN-1:0], quotient[XLEN-1:0]}
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge): state=IDLE, valid_o=0, res=0, counter=0. Reset has priority over every event.
//   A reset mid-division abandons the operation; no result is produced.
//  Output decodes: ready_o = (state==IDLE); valid_o = (state==DONE). res is registered and held stable while valid_o=1.
//  Accept: valid_i & ready_o at an edge. The block latches sign(data1), sign(data2), |data1|, |data2|.
//   Magnitudes are XLEN+1 bits unsigned (|-2^32| = 2^32 fits).
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE->DONE  on accept with data2==0. Divide-by-zero result: quotient = all ones, remainder = data1[XLEN-1:0].
//   IDLE->CALC  on accept with data2!=0. Clear partial remainder; counter=0.
//   CALC        one quotient bit per cycle, MSB first.
//               Shift {rem,dvd} left 1; trial = rem - |divisor|; if trial >= 0, rem=trial and qbit=1, else qbit=0.
//               Stays XLEN+1 (33) cycles; counter runs 0..XLEN, then CALC->FIX.
//   FIX         q = qsign ? -qmag : qmag, where qsign = s1^s2; r = s1 ? -rmag : rmag.
//               Truncate both to XLEN bits and load res. FIX->DONE.
//   DONE        hold res; on ready_i go DONE->IDLE (valid_o drops next cycle).
//  Latency (acceptance edge to first cycle with valid_o=1): 35 cycles normally, 1 cycle for divide-by-zero.
//  Throughput: one op in flight. No accept while in DONE, even if ready_i=1 in the same cycle.
//   Minimum spacing between accepts: latency + 1 cycle.
//  Arithmetic: truncated division (quotient rounds toward zero); remainder takes the dividend's sign.
//   Overflow -2^31/-1 with sign-extended 33-bit inputs yields q=0x80000000, r=0 via natural truncation.
//  valid_i is ignored outside IDLE. data1/data2 need not be held after accept.
//  ready_i is ignored outside DONE. valid_o never drops without ready_i (except on reset).
// TESTING
//  1 100/7 (33'h064, 33'h007) -> valid_o at +35 cycles.
//    res=64'h00000002_0000000E.
//  2 -7/2 (33'h1_FFFFFFF9, 33'h0_00000002) -> q=32'hFFFFFFFD, r=32'hFFFFFFFF.
//  3 Unsigned 0xFFFFFFFF/2 (33'h0_FFFFFFFF, 33'h002) -> res=64'h00000001_7FFFFFFF.
//    -2^31/-1 (33'h1_80000000, 33'h1_FFFFFFFF) -> res=64'h00000000_80000000.
//  4 5/0 -> valid_o 1 cycle after accept.
//    res=64'h00000005_FFFFFFFF.
//  5 Backpressure: hold ready_i=0 for 10 cycles in DONE -> res and valid_o stable, ready_o=0.
//    valid_i pulses are ignored. On ready_i=1: IDLE next cycle, ready_o=1.
//  6 rst_n=0 for 1 cycle at CALC cycle 10 -> next cycle state=IDLE, valid_o=0, res=0, ready_o=1.
//    A following 9/3 returns res=64'h00000000_00000003 after 35 cycles.

Source files
------------

// File: rtl/booth_divider.sv
// Iterative radix-2 restoring divider with valid/ready handshakes on both sides.
// Produces one signed or unsigned division result {remainder, quotient} per operation.
module booth_divider #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN:0]     data1,
  input  logic [XLEN:0]     data2,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [2*XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   counter;
  logic            s1, s2;
  logic [XLEN:0]   rem, quo, dvs;
  logic [XLEN:0]   abs1, abs2;
  logic [XLEN+1:0] shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            div_zero;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  // The magnitudes fit in XLEN+1 bits unsigned, so -(-2^XLEN) is still exact.
  always_comb begin
    abs1     = data1[XLEN] ? -data1 : data1;
    abs2     = data2[XLEN] ? -data2 : data2;
    div_zero = (data2 == '0);
    shifted  = {rem, quo[XLEN]};
    ge       = (shifted >= {1'b0, dvs});
    diff     = shifted[XLEN:0] - dvs;
    q_fix    = (s1 ^ s2) ? -quo[XLEN-1:0] : quo[XLEN-1:0];
    r_fix    = s1 ? -rem[XLEN-1:0] : rem[XLEN-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (valid_i) state_next = div_zero ? DONE : CALC;
      CALC: if (counter == CW'(XLEN)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      res     <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (valid_i) begin
            s1      <= data1[XLEN];
            s2      <= data2[XLEN];
            quo     <= abs1;
            dvs     <= abs2;
            rem     <= '0;
            counter <= '0;
            if (div_zero) res <= {data1[XLEN-1:0], {XLEN{1'b1}}};
          end
        end
        // The dividend register doubles as the quotient shift register.
        CALC: begin
          rem     <= ge ? diff : shifted[XLEN:0];
          quo     <= {quo[XLEN-1:0], ge};
          counter <= counter + 1'b1;
        end
        FIX: res <= {r_fix, q_fix};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed self-checking bench for booth_divider: signed/unsigned results,
// divide-by-zero, backpressure, mid-operation reset and back-to-back operations.
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [32:0] data1, data2;
  logic        valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [63:0] res;

  int errors = 0;
  int checks = 0;

  booth_divider #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .data1(data1), .data2(data2),
    .valid_i(valid_i), .ready_o(ready_o), .ready_i(ready_i),
    .valid_o(valid_o), .res(res)
  );

  always #5 clk = ~clk;

  // Presents operands for one edge, then counts cycles until valid_o (accept edge = 1).
  task automatic run_op(input logic [32:0] a, input logic [32:0] b,
                        output logic [63:0] r, output int lat);
    data1 = a; data2 = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; data1 = '0; data2 = '0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res;
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_o got=%b exp=1", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_o got=%b exp=0", valid_o); end
    checks++;
    if (res !== 64'h0) begin errors++; $display("[TB] FAIL reset_res got=%h exp=0", res); end
  endtask

  task automatic test_divide();
    logic [32:0] a_tab [7];
    logic [32:0] b_tab [7];
    logic [63:0] e_tab [7];
    logic [63:0] r;
    int lat;
    a_tab = '{33'h0_00000064, 33'h1_FFFFFFF9, 33'h0_FFFFFFFF, 33'h1_80000000,
              33'h1_FFFFFF9C, 33'h0_00000064, 33'h0_00000003};
    b_tab = '{33'h0_00000007, 33'h0_00000002, 33'h0_00000002, 33'h1_FFFFFFFF,
              33'h0_00000007, 33'h1_FFFFFFF9, 33'h0_00000007};
    e_tab = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFF,
              64'h00000000_80000000, 64'hFFFFFFFE_FFFFFFF2, 64'h00000002_FFFFFFF2,
              64'h00000003_00000000};
    for (int i = 0; i < 7; i++) begin
      run_op(a_tab[i], b_tab[i], r, lat);
      checks++;
      if (lat !== 35) begin errors++; $display("[TB] FAIL div%0d_latency got=%0d exp=35", i, lat); end
      checks++;
      if (r !== e_tab[i]) begin errors++; $display("[TB] FAIL div%0d_res got=%h exp=%h", i, r, e_tab[i]); end
      release_result();
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] r;
    int lat;
    run_op(33'h0_00000005, 33'h0_00000000, r, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("[TB] FAIL divzero_latency got=%0d exp=1", lat); end
    checks++;
    if (r !== 64'h00000005_FFFFFFFF) begin errors++; $display("[TB] FAIL divzero_res got=%h exp=00000005ffffffff", r); end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [63:0] r;
    int lat;
    run_op(33'h0_00000064, 33'h0_00000007, r, lat);
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0]; data1 = 33'h5; data2 = 33'h0;
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || res !== 64'h00000002_0000000E) begin
        errors++;
        $display("[TB] FAIL backpressure_hold%0d got v=%b r=%b res=%h exp v=1 r=0 res=000000020000000e",
                 i, valid_o, ready_o, res);
      end
    end
    valid_i = 1'b0;
    release_result();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL backpressure_release got r=%b v=%b exp r=1 v=0", ready_o, valid_o);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] r;
    int lat;
    data1 = 33'h64; data2 = 33'h7; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL midcalc_busy got ready_o=%b exp=0", ready_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || res !== 64'h0) begin
      errors++; $display("[TB] FAIL midcalc_reset got r=%b v=%b res=%h exp r=1 v=0 res=0", ready_o, valid_o, res);
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) lat++;
    end
    checks++;
    if (lat !== 0) begin errors++; $display("[TB] FAIL midcalc_no_result got=%0d valid cycles exp=0", lat); end
    run_op(33'h9, 33'h3, r, lat);
    checks++;
    if (lat !== 35 || r !== 64'h00000000_00000003) begin
      errors++; $display("[TB] FAIL after_reset_op got lat=%0d res=%h exp lat=35 res=0000000000000003", lat, r);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [63:0] r;
    int lat;
    run_op(33'h0_00000005, 33'h0_00000000, r, lat);
    // Offer a new operand while releasing the result: it must not be accepted.
    data1 = 33'h7; data2 = 33'h0; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL done_no_accept got r=%b v=%b exp r=1 v=0", ready_o, valid_o);
    end
    run_op(33'h1_FFFFFF9C, 33'h0_0000000A, r, lat);
    checks++;
    if (lat !== 35 || r !== 64'h00000000_FFFFFFF6) begin
      errors++; $display("[TB] FAIL back_to_back got lat=%0d res=%h exp lat=35 res=00000000fffffff6", lat, r);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
